pc_sequencer: RTL and testbench

//  Program-counter owner for the 8-bit MIPS fetch path; consumes the incrementer's +1 result and closes the loop.

---
 rtl/mips8_pkg.sv | 14 +
 rtl/pc_sequencer_incr.sv | 11 +
 rtl/pc_sequencer.sv | 124 ++++++++++++
 tb/tb_pc_sequencer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mips8_pkg.sv
// Shared constants and PC state type for the 8-bit MIPS fetch path.
package mips8_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned INC    = 1;
    localparam logic [ADDR_W-1:0] RESET_ADDR = 8'h00;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALT
    } pc_state_e;

endpackage

// File: rtl/pc_sequencer_incr.sv
// Sequential PC incrementer: pc + INC, wrapping modulo 2^ADDR_W.
module pc_sequencer_incr
    import mips8_pkg::*;
(
    input  logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] sum_c
);

    assign sum_c = pc + ADDR_W'(INC);

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter owner: issues fetches over valid/ready, picks next PC, handles stall/halt.
// Optional PC_OVERFLOW_TRAP_EN: sequential advance past the top address traps and halts instead of wrapping.
module pc_sequencer
    import mips8_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              halt,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              fetch_valid,
    output logic [ADDR_W-1:0] fetch_addr,
    input  logic              fetch_ready,
    output logic [ADDR_W-1:0] pc_plus1,
    output logic              halted,
    output logic              trap
);

`ifdef PC_OVERFLOW_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    pc_state_e         state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt;
    logic              outstanding;
    logic              pend_valid, pend_valid_nxt;
    logic [ADDR_W-1:0] pend_addr, pend_addr_nxt;
    logic              halt_pend, halt_pend_nxt;
    logic              trap_q, trap_nxt;
    logic              accept;
    logic              redirect;
    logic [ADDR_W-1:0] redir_addr;
    logic              halt_req;

    pc_sequencer_incr u_incr (
        .pc    (pc),
        .sum_c (pc_plus1)
    );

    // Request handshake; an outstanding request stays valid regardless of stall
    always_comb begin
        fetch_valid = (state == RUN) && (!stall || outstanding);
        accept      = fetch_valid && fetch_ready;
        redirect    = jump || branch_taken;
        redir_addr  = jump ? jump_target : branch_target;
        halt_req    = halt || halt_pend;
    end

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        pend_valid_nxt = pend_valid;
        pend_addr_nxt  = pend_addr;
        halt_pend_nxt  = halt_pend;
        trap_nxt       = trap_q;
        unique case (state)
            IDLE: begin
                state_nxt     = RUN;
                halt_pend_nxt = halt;
                if (redirect && !halt) pc_nxt = redir_addr;
            end
            RUN: begin
                if (halt) halt_pend_nxt = 1'b1;
                if (accept) begin
                    pend_valid_nxt = 1'b0;
                    if (pend_valid) begin
                        pc_nxt = pend_addr;
                    end else if (redirect && !halt_req) begin
                        pc_nxt = redir_addr;
                    end else if (TRAP_EN && (pc == '1)) begin
                        trap_nxt  = 1'b1;
                        state_nxt = HALT;
                    end else begin
                        pc_nxt = pc_plus1;
                    end
                    if (halt_req) state_nxt = HALT;
                end else if (fetch_valid) begin
                    // Address must hold while waiting; park the redirect until accept
                    if (redirect && !halt_req) begin
                        pend_valid_nxt = 1'b1;
                        pend_addr_nxt  = redir_addr;
                    end
                end else begin
                    if (halt_req)      state_nxt = HALT;
                    else if (redirect) pc_nxt    = redir_addr;
                end
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            pc          <= RESET_ADDR;
            outstanding <= 1'b0;
            pend_valid  <= 1'b0;
            pend_addr   <= RESET_ADDR;
            halt_pend   <= 1'b0;
            trap_q      <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            outstanding <= fetch_valid && !fetch_ready;
            pend_valid  <= pend_valid_nxt;
            pend_addr   <= pend_addr_nxt;
            halt_pend   <= halt_pend_nxt;
            trap_q      <= trap_nxt;
        end
    end

    assign fetch_addr = pc;
    assign halted     = (state == HALT);
    assign trap       = trap_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized bench for pc_sequencer against a cycle-level behavioural model, plus directed scenarios.
module tb_pc_sequencer;

    logic       clk;
    logic       reset;
    logic       stall, halt, jump, branch_taken, fetch_ready;
    logic [7:0] jump_target, branch_target;
    logic       fetch_valid, halted, trap;
    logic [7:0] fetch_addr, pc_plus1;

    pc_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .halt          (halt),
        .jump          (jump),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .fetch_valid   (fetch_valid),
        .fetch_addr    (fetch_addr),
        .fetch_ready   (fetch_ready),
        .pc_plus1      (pc_plus1),
        .halted        (halted),
        .trap          (trap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef PC_OVERFLOW_TRAP_EN
    bit trap_en = 1'b1;
`else
    bit trap_en = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int n_cycle = 0;

    // Model: phase 0 = waiting to start, 1 = fetching, 2 = stopped
    int         m_phase = 0;
    logic [7:0] m_pc    = 8'h00;
    bit         m_wait  = 1'b0;
    bit         m_armed = 1'b0;
    bit         m_trap  = 1'b0;
    logic [7:0] m_pend[$];
    bit         exp_valid;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, n_cycle);
        end
    endtask

    task automatic model_check();
        exp_valid = (m_phase == 1) && (!stall || m_wait);
        chk("fetch_valid", int'(fetch_valid), int'(exp_valid));
        chk("fetch_addr",  int'(fetch_addr),  int'(m_pc));
        chk("pc_plus1",    int'(pc_plus1),    (int'(m_pc) + 1) % 256);
        chk("halted",      int'(halted),      int'(m_phase == 2));
        chk("trap",        int'(trap),        int'(m_trap));
    endtask

    task automatic model_step();
        bit         redir, stopping;
        logic [7:0] tgt;
        redir = jump || branch_taken;
        tgt   = jump ? jump_target : branch_target;
        if (!reset) begin
            m_phase = 0; m_pc = 8'h00; m_wait = 0; m_armed = 0; m_trap = 0;
            m_pend.delete();
        end else if (m_phase == 0) begin
            m_phase = 1;
            m_armed = halt;
            if (redir && !halt) m_pc = tgt;
        end else if (m_phase == 1) begin
            stopping = halt || m_armed;
            if (halt) m_armed = 1;
            if (exp_valid && fetch_ready) begin
                if (m_pend.size() > 0)          m_pc = m_pend[0];
                else if (redir && !stopping)    m_pc = tgt;
                else if (trap_en && m_pc == 8'hFF) begin m_trap = 1; m_phase = 2; end
                else                            m_pc = 8'((int'(m_pc) + 1) % 256);
                m_pend.delete();
                m_wait = 0;
                if (stopping) m_phase = 2;
            end else if (exp_valid) begin
                m_wait = 1;
                if (redir && !stopping) begin
                    m_pend.delete();
                    m_pend.push_back(tgt);
                end
            end else begin
                m_wait = 0;
                if (stopping)   m_phase = 2;
                else if (redir) m_pc = tgt;
            end
        end
    endtask

    // One clock: drive at negedge, compare shortly after, advance model at posedge
    task automatic cycle(input logic r, input logic st, input logic hl,
                         input logic j, input logic [7:0] jt,
                         input logic b, input logic [7:0] bt, input logic rdy,
                         output logic v, output logic [7:0] a,
                         output logic h, output logic t);
        @(negedge clk);
        reset = r; stall = st; halt = hl; jump = j; jump_target = jt;
        branch_taken = b; branch_target = bt; fetch_ready = rdy;
        #1;
        model_check();
        v = fetch_valid; a = fetch_addr; h = halted; t = trap;
        @(posedge clk);
        model_step();
        n_cycle++;
    endtask

    logic       v, h, t;
    logic [7:0] a;

    initial begin
        reset = 1'b0; stall = 1'b0; halt = 1'b0; jump = 1'b0; branch_taken = 1'b0;
        jump_target = 8'h00; branch_target = 8'h00; fetch_ready = 1'b0;

        // Reset state and start-up latency, sequential fetch
        cycle(0, 0, 0, 0, 8'h00, 0, 8'h00, 1, v, a, h, t);
        cycle(0, 0, 0, 0, 8'h00, 0, 8'h00, 1, v, a, h, t);
        chk("rst_valid", int'(v), 0);
        chk("rst_addr", int'(a), 8'h00);
        chk("rst_trap", int'(t), 0);
        cycle(1, 0, 0, 0, 8'h00, 0, 8'h00, 1, v, a, h, t);
        chk("t1_valid_c1", int'(v), 0);
        for (int i = 0; i < 4; i++) begin
            cycle(1, 0, 0, 0, 8'h00, 0, 8'h00, 1, v, a, h, t);
            chk("t1_valid", int'(v), 1);
            chk("t1_addr", int'(a), i);
        end

        // Redirect parked while not ready
        cycle(1, 0, 0, 0, 8'h00, 0, 8'h00, 1, v, a, h, t);
        cycle(1, 0, 0, 1, 8'h40, 0, 8'h00, 0, v, a, h, t);
        chk("t2_addr_hold0", int'(a), 8'h05);
        cycle(1, 0, 0, 0, 8'h00, 0, 8'h00, 0, v, a, h, t);
        chk("t2_addr_hold1", int'(a), 8'h05);
        chk("t2_valid_hold", int'(v), 1);
        cycle(1, 0, 0, 0, 8'h00, 0, 8'h00, 1, v, a, h, t);
        chk("t2_addr_accept", int'(a), 8'h05);

        // Jump beats branch
        cycle(1, 0, 0, 1, 8'h20, 1, 8'h30, 1, v, a, h, t);
        chk("t2_addr_after", int'(a), 8'h40);

        // Stall with a redirect landing directly in pc
        cycle(1, 1, 0, 0, 8'h00, 0, 8'h00, 1, v, a, h, t);
        chk("t3_addr", int'(a), 8'h20);
        chk("t4_stall_valid", int'(v), 0);
        cycle(1, 1, 0, 0, 8'h00, 1, 8'h10, 1, v, a, h, t);
        chk("t4_stall_addr", int'(a), 8'h20);
        cycle(1, 0, 0, 1, 8'hFF, 0, 8'h00, 1, v, a, h, t);
        chk("t4_after_stall", int'(a), 8'h10);

        // Top-of-range sequential advance
        cycle(1, 0, 0, 0, 8'h00, 0, 8'h00, 1, v, a, h, t);
        chk("t5_addr_ff", int'(a), 8'hFF);
        cycle(1, 0, 0, 0, 8'h00, 0, 8'h00, 1, v, a, h, t);
`ifdef PC_OVERFLOW_TRAP_EN
        chk("t5_trap", int'(t), 1);
        chk("t5_halted", int'(h), 1);
        chk("t5_valid", int'(v), 0);
`else
        chk("t5_wrap_addr", int'(a), 8'h00);
        chk("t5_trap", int'(t), 0);
        chk("t5_valid", int'(v), 1);
`endif

        // Halt while a request is outstanding, then reset
        cycle(0, 0, 0, 0, 8'h00, 0, 8'h00, 0, v, a, h, t);
        cycle(0, 0, 0, 0, 8'h00, 0, 8'h00, 0, v, a, h, t);
        cycle(1, 0, 0, 1, 8'h08, 0, 8'h00, 0, v, a, h, t);
        cycle(1, 0, 1, 0, 8'h00, 0, 8'h00, 0, v, a, h, t);
        chk("t6_addr", int'(a), 8'h08);
        chk("t6_valid0", int'(v), 1);
        cycle(1, 0, 0, 0, 8'h00, 0, 8'h00, 0, v, a, h, t);
        chk("t6_valid1", int'(v), 1);
        chk("t6_not_halted", int'(h), 0);
        cycle(1, 0, 0, 0, 8'h00, 0, 8'h00, 1, v, a, h, t);
        cycle(1, 0, 0, 0, 8'h00, 0, 8'h00, 1, v, a, h, t);
        chk("t6_halted", int'(h), 1);
        chk("t6_valid_off", int'(v), 0);
        cycle(0, 0, 0, 0, 8'h00, 0, 8'h00, 1, v, a, h, t);
        cycle(1, 0, 0, 0, 8'h00, 0, 8'h00, 1, v, a, h, t);
        chk("t6_rst_halted", int'(h), 0);
        chk("t6_rst_addr", int'(a), 8'h00);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            logic       r, st, hl, j, b, rdy;
            logic [7:0] jt, bt;
            r   = ($urandom_range(79, 0) != 0);
            st  = ($urandom_range(3, 0) == 0);
            hl  = ($urandom_range(99, 0) == 0);
            j   = ($urandom_range(9, 0) == 0);
            b   = ($urandom_range(9, 0) == 0);
            rdy = ($urandom_range(4, 0) < 3);
            jt  = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 252)) : 8'($urandom);
            bt  = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 252)) : 8'($urandom);
            cycle(r, st, hl, j, jt, b, bt, rdy, v, a, h, t);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
